// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with run-time seed load, zero-state recovery and wrap detection.
// Optional period-measurement counter enabled by defining LFSR_GEN_PERIOD_CNT_EN.
module lfsr_gen #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
   parameter int               STEPS = 1,
   parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] lfsr_out,
   output logic             wrap,
   output logic             lockup
`ifdef LFSR_GEN_PERIOD_CNT_EN
   ,
   output logic [WIDTH:0]   period_out,
   output logic             period_valid
`endif
);

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic             wrap_q, wrap_d;
   logic             lockup_q, lockup_d;
   logic [WIDTH-1:0] adv;
   logic [WIDTH-1:0] seed_fix;
   logic             adv_go;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      return {^(s & TAPS), s[WIDTH-1:1]};
   endfunction

   // STEPS single shifts chained combinationally
   always_comb begin
      adv = state_q;
      for (int i = 0; i < STEPS; i++) begin
         adv = lfsr_step(adv);
      end
   end

   assign seed_fix = (seed_in == '0) ? SEED : seed_in;

   always_comb begin
      state_d  = state_q;
      seed_d   = seed_q;
      wrap_d   = 1'b0;
      lockup_d = 1'b0;
      adv_go   = 1'b0;
      if (load) begin
         state_d = seed_fix;
         seed_d  = seed_fix;
      end else if (state_q == '0) begin
         state_d  = SEED;
         lockup_d = 1'b1;
      end else if (en) begin
         state_d = adv;
         wrap_d  = (adv == seed_q);
         adv_go  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= SEED;
         seed_q   <= SEED;
         wrap_q   <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         seed_q   <= seed_d;
         wrap_q   <= wrap_d;
         lockup_q <= lockup_d;
      end
   end

   assign lfsr_out = state_q;
   assign wrap     = wrap_q;
   assign lockup   = lockup_q;

`ifdef LFSR_GEN_PERIOD_CNT_EN
   logic [WIDTH:0] cnt_q, cnt_d;
   logic [WIDTH:0] period_q, period_d;
   logic           pvalid_q, pvalid_d;

   // Counter tracks advances since the last wrap/load/recovery; saturates rather than rolling over
   always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      pvalid_d = 1'b0;
      if (load || lockup_d) begin
         cnt_d = '0;
      end else if (adv_go) begin
         if (wrap_d) begin
            period_d = cnt_q + 1'b1;
            pvalid_d = 1'b1;
            cnt_d    = '0;
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q    <= '0;
         period_q <= '0;
         pvalid_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_d;
         pvalid_q <= pvalid_d;
      end
   end

   assign period_out   = period_q;
   assign period_valid = pvalid_q;
`endif

endmodule
